// File: rtl/program_loader_pkg.sv
// Shared constants and state encoding for the byte-serial program loader.
// The memory is byte-addressed; headers count 32-bit words of four byte lanes.
package program_loader_pkg;

    localparam int DATAWIDTH = 8;
    localparam int ADDWIDTH  = 7;
    localparam int MAXWORDS  = 2 ** (ADDWIDTH - 2);
    localparam int LANES     = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        LOAD  = 3'd2,
        DRAIN = 3'd3,
        RUN   = 3'd4,
        ERR   = 3'd5
    } state_t;

endpackage

// File: rtl/program_loader.sv
// Boot loader: takes a word-count header plus program bytes over a valid/ready
// handshake, writes them to memory from address 0, then releases the CPU.
module program_loader
    import program_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic                  byte_valid,
    input  logic [DATAWIDTH-1:0]  byte_in,
    output logic                  byte_ready,
    output logic                  mem_wrEn,
    output logic [ADDWIDTH-1:0]   mem_writeAdd,
    output logic [DATAWIDTH-1:0]  mem_writeData,
    output logic                  cpu_run,
    output logic                  load_err,
    output logic [ADDWIDTH-2:0]   words_loaded,
    output state_t                state
);

    // Handshake: a byte moves on a rising edge where byte_valid && byte_ready.
    // byte_ready is registered alongside state, so it is high exactly in HDR/LOAD.
    logic                accept;
    logic                hdr_ok;
    logic [ADDWIDTH:0]   hdr_len;
    logic [ADDWIDTH:0]   byte_cnt;
    logic [ADDWIDTH:0]   len_bytes;

    assign accept  = byte_valid && byte_ready;
    assign hdr_ok  = (byte_in != '0) && (byte_in <= DATAWIDTH'(MAXWORDS));
    assign hdr_len = (ADDWIDTH+1)'(byte_in[ADDWIDTH-2:0]) * (ADDWIDTH+1)'(LANES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            byte_ready    <= 1'b0;
            mem_wrEn      <= 1'b0;
            mem_writeAdd  <= '0;
            mem_writeData <= '0;
            cpu_run       <= 1'b0;
            load_err      <= 1'b0;
            words_loaded  <= '0;
            byte_cnt      <= '0;
            len_bytes     <= '0;
        end else begin
            mem_wrEn <= 1'b0;
            case (state)
                IDLE, RUN, ERR: begin
                    if (load_start) begin
                        state      <= HDR;
                        byte_ready <= 1'b1;
                        cpu_run    <= 1'b0;
                    end
                end
                HDR: begin
                    if (accept) begin
                        if (hdr_ok) begin
                            len_bytes    <= hdr_len;
                            byte_cnt     <= '0;
                            words_loaded <= '0;
                            load_err     <= 1'b0;
                            state        <= LOAD;
                        end else begin
                            load_err   <= 1'b1;
                            byte_ready <= 1'b0;
                            state      <= ERR;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        mem_wrEn      <= 1'b1;
                        mem_writeAdd  <= byte_cnt[ADDWIDTH-1:0];
                        mem_writeData <= byte_in;
                        byte_cnt      <= byte_cnt + 1'b1;
                        if (byte_cnt[1:0] == 2'(LANES - 1))
                            words_loaded <= words_loaded + 1'b1;
                        // The final write leaves in the DRAIN cycle.
                        if (byte_cnt == len_bytes - 1'b1) begin
                            byte_ready <= 1'b0;
                            state      <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    cpu_run <= 1'b1;
                    state   <= RUN;
                end
                default: begin
                    byte_ready <= 1'b0;
                    cpu_run    <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: random bytes through a phase-level loader model,
// with expected and observed memory writes time-stamped and compared per scenario.
module tb_program_loader;
    import program_loader_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 load_start = 1'b0;
    logic                 byte_valid = 1'b0;
    logic [DATAWIDTH-1:0] byte_in = '0;
    logic                 byte_ready, mem_wrEn, cpu_run, load_err;
    logic [ADDWIDTH-1:0]  mem_writeAdd;
    logic [DATAWIDTH-1:0] mem_writeData;
    logic [ADDWIDTH-2:0]  words_loaded;
    state_t               state;

    always #5 clk = ~clk;

    program_loader dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start),
        .byte_valid(byte_valid), .byte_in(byte_in), .byte_ready(byte_ready),
        .mem_wrEn(mem_wrEn), .mem_writeAdd(mem_writeAdd),
        .mem_writeData(mem_writeData), .cpu_run(cpu_run), .load_err(load_err),
        .words_loaded(words_loaded), .state(state)
    );

    typedef enum int {P_IDLE, P_HDR, P_LOAD, P_DRAIN, P_RUN, P_ERR} phase_t;
    phase_t      m_phase = P_IDLE;
    int          m_len, m_cnt, m_words;
    bit          m_err, m_acc;
    logic [30:0] exp_q[$];
    logic [30:0] obs_q[$];
    logic [30:0] e, o;
    int          cyc, vectors, miscompares, ready_diff, run_diff;

    // One clock: model steps on the inputs presented, then DUT writes are logged.
    task automatic cycle();
        bit rdy;
        rdy   = (m_phase == P_HDR) || (m_phase == P_LOAD);
        m_acc = byte_valid && rdy;
        if (byte_ready !== rdy) ready_diff++;
        if (cpu_run !== (m_phase == P_RUN)) run_diff++;
        cyc++;
        case (m_phase)
            P_IDLE, P_RUN, P_ERR: if (load_start) m_phase = P_HDR;
            P_HDR: if (m_acc) begin
                if (byte_in >= 1 && byte_in <= MAXWORDS) begin
                    m_len = 4 * int'(byte_in); m_cnt = 0; m_words = 0; m_err = 0;
                    m_phase = P_LOAD;
                end else begin
                    m_err = 1; m_phase = P_ERR;
                end
            end
            P_LOAD: if (m_acc) begin
                exp_q.push_back({cyc[15:0], 7'(m_cnt), byte_in});
                m_cnt++;
                m_words = m_cnt / 4;
                if (m_cnt == m_len) m_phase = P_DRAIN;
            end
            P_DRAIN: m_phase = P_RUN;
            default: m_phase = P_IDLE;
        endcase
        @(posedge clk);
        @(negedge clk);
        if (mem_wrEn === 1'b1) obs_q.push_back({cyc[15:0], mem_writeAdd, mem_writeData});
    endtask

    task automatic do_start();
        load_start = 1'b1;
        cycle();
        load_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit throttle);
        bit gap;
        gap = throttle;
        m_acc = 0;
        for (int i = 0; i < 20 && !m_acc; i++) begin
            byte_valid = !(throttle && gap);
            byte_in    = byte_valid ? b : 8'($urandom);
            gap        = !gap;
            cycle();
        end
        byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #3;
        vectors++;
        if ({byte_ready, mem_wrEn, cpu_run, load_err} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b, expected 0000", {byte_ready, mem_wrEn, cpu_run, load_err});
        end
        vectors++;
        if ({mem_writeAdd, mem_writeData, words_loaded} !== 21'd0) begin
            miscompares++;
            $display("FAIL reset_buses: got a=%h d=%h w=%0d, expected all 0", mem_writeAdd, mem_writeData, words_loaded);
        end
        vectors++;
        if (state !== IDLE) begin
            miscompares++;
            $display("FAIL reset_state: got %0d, expected %0d", state, IDLE);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            byte_valid = 1'b1; byte_in = 8'($urandom);
            cycle();
        end
        byte_valid = 1'b0;
        vectors++;
        if (state !== IDLE || obs_q.size() !== 0) begin
            miscompares++;
            $display("FAIL idle_ignore: got state=%0d writes=%0d, expected state=0 writes=0", state, obs_q.size());
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_basic();
        logic [7:0] prog[8];
        prog = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        do_start();
        send(8'h02, 1'b0);
        for (int i = 0; i < 8; i++) send(prog[i], 1'b0);
        vectors++;
        if (state !== DRAIN || cpu_run !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_drain: got state=%0d run=%b, expected state=3 run=0", state, cpu_run);
        end
        cycle();
        vectors++;
        if (cpu_run !== 1'b1 || words_loaded !== 6'd2) begin
            miscompares++;
            $display("FAIL basic_run: got run=%b words=%0d, expected run=1 words=2", cpu_run, words_loaded);
        end
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL basic_count: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL basic_write: got t=%0d a=%h d=%h, expected t=%0d a=%h d=%h", o[30:15], o[14:8], o[7:0], e[30:15], e[14:8], e[7:0]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_illegal();
        logic [7:0] hdrs[2];
        hdrs = '{8'h00, 8'h21};
        for (int h = 0; h < 2; h++) begin
            do_start();
            send(hdrs[h], 1'b0);
            for (int i = 0; i < 3; i++) begin
                byte_valid = 1'b1; byte_in = 8'($urandom);
                cycle();
            end
            byte_valid = 1'b0;
            vectors++;
            if (load_err !== 1'b1 || state !== ERR || byte_ready !== 1'b0 || cpu_run !== 1'b0) begin
                miscompares++;
                $display("FAIL illegal_hdr_%h: got err=%b state=%0d ready=%b run=%b, expected 1 5 0 0", hdrs[h], load_err, state, byte_ready, cpu_run);
            end
            vectors++;
            if (obs_q.size() !== 0 || words_loaded !== 6'(m_words)) begin
                miscompares++;
                $display("FAIL illegal_side_%h: got writes=%0d words=%0d, expected 0 and %0d", hdrs[h], obs_q.size(), words_loaded, m_words);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_full();
        do_start();
        send(8'h20, 1'b0);
        for (int i = 0; i < 128; i++) send(8'($urandom), 1'b0);
        vectors++;
        if (mem_writeAdd !== 7'h7F || state !== DRAIN || load_err !== 1'b0) begin
            miscompares++;
            $display("FAIL full_last: got a=%h state=%0d err=%b, expected a=7f state=3 err=0", mem_writeAdd, state, load_err);
        end
        cycle();
        vectors++;
        if (cpu_run !== 1'b1 || words_loaded !== 6'd32 || mem_wrEn !== 1'b0) begin
            miscompares++;
            $display("FAIL full_run: got run=%b words=%0d wr=%b, expected 1 32 0", cpu_run, words_loaded, mem_wrEn);
        end
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL full_count: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL full_write: got t=%0d a=%h d=%h, expected t=%0d a=%h d=%h", o[30:15], o[14:8], o[7:0], e[30:15], e[14:8], e[7:0]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_throttle();
        do_start();
        send(8'h01, 1'b1);
        for (int i = 0; i < 4; i++) send(8'($urandom), 1'b1);
        for (int i = 0; i < 3; i++) begin
            byte_valid = 1'b1; byte_in = 8'($urandom);
            cycle();
        end
        byte_valid = 1'b0;
        vectors++;
        if (obs_q.size() !== 4 || exp_q.size() !== 4) begin
            miscompares++;
            $display("FAIL throttle_count: got %0d writes, expected 4 (model %0d)", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL throttle_write: got t=%0d a=%h d=%h, expected t=%0d a=%h d=%h", o[30:15], o[14:8], o[7:0], e[30:15], e[14:8], e[7:0]);
            end
        end
        vectors++;
        if (ready_diff !== 0 || run_diff !== 0) begin
            miscompares++;
            $display("FAIL throttle_trace: got ready_diff=%0d run_diff=%0d, expected 0 0", ready_diff, run_diff);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reload();
        do_start();
        vectors++;
        if (cpu_run !== 1'b0 || state !== HDR || byte_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reload_drop: got run=%b state=%0d ready=%b, expected 0 1 1", cpu_run, state, byte_ready);
        end
        send(8'h01, 1'b0);
        for (int i = 0; i < 4; i++) send(8'($urandom), 1'b0);
        cycle();
        vectors++;
        if (cpu_run !== 1'b1 || load_err !== 1'b0 || words_loaded !== 6'd1) begin
            miscompares++;
            $display("FAIL reload_run: got run=%b err=%b words=%0d, expected 1 0 1", cpu_run, load_err, words_loaded);
        end
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL reload_count: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL reload_write: got t=%0d a=%h d=%h, expected t=%0d a=%h d=%h", o[30:15], o[14:8], o[7:0], e[30:15], e[14:8], e[7:0]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid();
        do_start();
        send(8'h02, 1'b0);
        for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({byte_ready, mem_wrEn, cpu_run, load_err} !== 4'b0 || state !== IDLE ||
            {mem_writeAdd, mem_writeData, words_loaded} !== 21'd0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got ready=%b wr=%b run=%b err=%b state=%0d a=%h d=%h w=%0d, expected all 0",
                     byte_ready, mem_wrEn, cpu_run, load_err, state, mem_writeAdd, mem_writeData, words_loaded);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_phase = P_IDLE; m_err = 0; m_words = 0;
        do_start();
        send(8'h01, 1'b0);
        for (int i = 0; i < 4; i++) send(8'($urandom), 1'b0);
        cycle();
        vectors++;
        if (obs_q.size() !== 7 || exp_q.size() !== 7) begin
            miscompares++;
            $display("FAIL midreset_count: got %0d writes, expected 7 (model %0d)", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL midreset_write: got t=%0d a=%h d=%h, expected t=%0d a=%h d=%h", o[30:15], o[14:8], o[7:0], e[30:15], e[14:8], e[7:0]);
            end
        end
        vectors++;
        if (cpu_run !== 1'b1 || ready_diff !== 0 || run_diff !== 0) begin
            miscompares++;
            $display("FAIL midreset_trace: got run=%b ready_diff=%0d run_diff=%0d, expected 1 0 0", cpu_run, ready_diff, run_diff);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_illegal();
        test_full();
        test_throttle();
        test_reload();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

endmodule
